// File: rtl/axis_pkt_tx.sv
// axis_pkt_tx
// Store-and-forward AXI4-Stream packet transmitter. A local producer writes
// words (with an end-of-packet flag) into a circular buffer; a packet only
// becomes visible on the master port once its last word has been stored, so
// m_tvalid never drops in the middle of a packet.
//
// Optional feature macro: AXIS_PKT_TX_ABORT_EN
//   When defined, adds the wr_abort input which discards the uncommitted
//   partial packet by pulling wr_ptr back to the commit boundary.
//
// Parameters:
//   DATA_WIDTH  width of wr_data / m_tdata
//   DEPTH       buffer depth in words (power of 2, >= 4)
//   CNT_W       derived width of pointers, occupancy and packet counter
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   wr_en/wr_data/wr_last  producer write interface
//   wr_abort               (AXIS_PKT_TX_ABORT_EN only) drop partial packet
//   wr_full                buffer holds DEPTH words
//   overflow               sticky: a write was attempted while full
//   m_tvalid/m_tready/m_tdata/m_tlast  AXI4-Stream master
//   pkt_count              committed packets not yet fully sent
//   occupancy              words in buffer, including an uncommitted partial
module axis_pkt_tx #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
`ifdef AXIS_PKT_TX_ABORT_EN
    input  logic                  wr_abort,
`endif
    output logic                  wr_full,
    output logic                  overflow,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic [CNT_W-1:0]      pkt_count,
    output logic [CNT_W-1:0]      occupancy
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    // Each entry holds {last, data}.
    logic [DATA_WIDTH:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so that full and empty differ.
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cm_ptr;
    logic [CNT_W-1:0] rd_ptr;

    logic             abort;
    logic             wr_accept;
    logic             rd_hs;
    logic [DATA_WIDTH:0] rd_entry;
    logic             pkt_inc;
    logic             pkt_dec;

`ifdef AXIS_PKT_TX_ABORT_EN
    assign abort = wr_abort;
`else
    assign abort = 1'b0;
`endif

    assign occupancy = wr_ptr - rd_ptr;
    assign wr_full   = (occupancy == DEPTH_CNT);

    // Abort wins over a same-cycle write; that write is discarded too.
    assign wr_accept = wr_en && !wr_full && !abort;

    // Only committed words are visible, which keeps valid stable mid-packet.
    assign m_tvalid  = (rd_ptr != cm_ptr);
    assign rd_entry  = mem[rd_ptr[AW-1:0]];
    assign m_tdata   = rd_entry[DATA_WIDTH-1:0];
    assign m_tlast   = rd_entry[DATA_WIDTH];
    assign rd_hs     = m_tvalid && m_tready;

    assign pkt_inc   = wr_accept && wr_last;
    assign pkt_dec   = rd_hs && m_tlast;

    // Storage array needs no reset: entries are only read once committed.
    always_ff @(posedge aclk) begin
        if (wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            cm_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (abort) begin
                wr_ptr <= cm_ptr;
            end else if (wr_accept) begin
                wr_ptr <= wr_ptr + ONE;
                // The commit boundary moves to just past the last word.
                if (wr_last) begin
                    cm_ptr <= wr_ptr + ONE;
                end
            end

            if (rd_hs) begin
                rd_ptr <= rd_ptr + ONE;
            end

            // Any write attempt against a full buffer is recorded, even one
            // that an abort would have discarded anyway.
            if (wr_en && wr_full) begin
                overflow <= 1'b1;
            end

            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_count <= pkt_count + ONE;
                2'b01:   pkt_count <= pkt_count - ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_tx.sv
// tb_axis_pkt_tx
// Directed self-checking bench for axis_pkt_tx (DATA_WIDTH=32, DEPTH=16).
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at that same point, well away from the next active edge.
module tb_axis_pkt_tx;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 16;
    localparam int CNT_W      = $clog2(DEPTH) + 1;

    logic                  aclk;
    logic                  aresetn;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
`ifdef AXIS_PKT_TX_ABORT_EN
    logic                  wr_abort;
`endif
    logic                  wr_full;
    logic                  overflow;
    logic                  m_tvalid;
    logic                  m_tready;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tlast;
    logic [CNT_W-1:0]      pkt_count;
    logic [CNT_W-1:0]      occupancy;

    int tests_run    = 0;
    int tests_failed = 0;
    int beats;

    axis_pkt_tx #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
`ifdef AXIS_PKT_TX_ABORT_EN
        .wr_abort  (wr_abort),
`endif
        .wr_full   (wr_full),
        .overflow  (overflow),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .pkt_count (pkt_count),
        .occupancy (occupancy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Drive one cycle of producer/consumer inputs, then return after the edge.
    task automatic applyStimulus(input logic en, input logic [31:0] data,
                                 input logic last, input logic rdy);
        wr_en    = en;
        wr_data  = data;
        wr_last  = last;
        m_tready = rdy;
        tick();
        wr_en    = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        aresetn  = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        m_tready = 1'b0;
`ifdef AXIS_PKT_TX_ABORT_EN
        wr_abort = 1'b0;
`endif
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("rst_tvalid",   32'(m_tvalid),  0);
        checkOutput("rst_full",     32'(wr_full),   0);
        checkOutput("rst_overflow", 32'(overflow),  0);
        checkOutput("rst_pkt",      32'(pkt_count), 0);
        checkOutput("rst_occ",      32'(occupancy), 0);
        #3 aresetn = 1'b1;
        tick();

        // Single packet 0x11,0x22,0x33 with ready held high.
        applyStimulus(1, 'h11, 0, 1);
        applyStimulus(1, 'h22, 0, 1);
        checkOutput("single_no_early_valid", 32'(m_tvalid), 0);
        applyStimulus(1, 'h33, 1, 1);
        checkOutput("single_valid_latency", 32'(m_tvalid), 1);
        checkOutput("single_beat0",  m_tdata, 'h11);
        checkOutput("single_last0",  32'(m_tlast), 0);
        checkOutput("single_pkt1",   32'(pkt_count), 1);
        tick();
        checkOutput("single_beat1",  m_tdata, 'h22);
        checkOutput("single_last1",  32'(m_tlast), 0);
        tick();
        checkOutput("single_beat2",  m_tdata, 'h33);
        checkOutput("single_last2",  32'(m_tlast), 1);
        checkOutput("single_pkt_mid", 32'(pkt_count), 1);
        tick();
        checkOutput("single_idle",   32'(m_tvalid), 0);
        checkOutput("single_pkt0",   32'(pkt_count), 0);
        checkOutput("single_occ0",   32'(occupancy), 0);

        // Backpressure: data must hold while ready is low.
        applyStimulus(1, 'hAA, 0, 0);
        applyStimulus(1, 'hBB, 1, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_tvalid", 32'(m_tvalid), 1);
            checkOutput("hold_tdata",  m_tdata, 'hAA);
            tick();
        end
        m_tready = 1'b1;
        checkOutput("hold_rel_beat0", m_tdata, 'hAA);
        tick();
        checkOutput("hold_rel_beat1", m_tdata, 'hBB);
        checkOutput("hold_rel_last1", 32'(m_tlast), 1);
        tick();
        checkOutput("hold_done", 32'(m_tvalid), 0);

        // A partial packet is not released until its last word arrives.
        for (int i = 0; i < 4; i++) applyStimulus(1, 'h40 + i, 0, 1);
        checkOutput("partial_tvalid", 32'(m_tvalid), 0);
        checkOutput("partial_occ",    32'(occupancy), 4);
        applyStimulus(1, 'h44, 1, 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("partial_beat_valid", 32'(m_tvalid), 1);
            checkOutput("partial_beat_data",  m_tdata, 'h40 + i);
            checkOutput("partial_beat_last",  32'(m_tlast), (i == 4) ? 1 : 0);
            tick();
        end
        checkOutput("partial_done", 32'(m_tvalid), 0);

        // Fill to DEPTH, then one extra write that must be dropped.
        for (int i = 0; i < 16; i++) applyStimulus(1, 'h100 + i, (i == 15) ? 1'b1 : 1'b0, 0);
        checkOutput("full_flag",     32'(wr_full),   1);
        checkOutput("full_occ",      32'(occupancy), 16);
        checkOutput("full_pkt",      32'(pkt_count), 1);
        checkOutput("full_no_ovf",   32'(overflow),  0);
        applyStimulus(1, 'hDEAD, 1, 0);
        checkOutput("full_ovf",      32'(overflow),  1);
        checkOutput("full_occ_kept", 32'(occupancy), 16);
        checkOutput("full_pkt_kept", 32'(pkt_count), 1);
        m_tready = 1'b1;
        beats = 0;
        for (int c = 0; c < 40 && m_tvalid; c++) begin
            checkOutput("full_drain_data", m_tdata, 'h100 + beats);
            checkOutput("full_drain_last", 32'(m_tlast), (beats == 15) ? 1 : 0);
            beats++;
            tick();
        end
        checkOutput("full_drain_beats", beats, 16);
        checkOutput("full_drain_occ",   32'(occupancy), 0);
        checkOutput("full_drain_flag",  32'(wr_full), 0);

        // Packet B commits on the same edge that packet A's last beat leaves.
        applyStimulus(1, 'h50, 0, 1);
        applyStimulus(1, 'h51, 1, 1);
        checkOutput("simul_a0",    m_tdata, 'h50);
        checkOutput("simul_pkt_a", 32'(pkt_count), 1);
        applyStimulus(1, 'h60, 0, 1);
        checkOutput("simul_a1",      m_tdata, 'h51);
        checkOutput("simul_a1_last", 32'(m_tlast), 1);
        applyStimulus(1, 'h61, 1, 1);
        checkOutput("simul_pkt_same", 32'(pkt_count), 1);
        checkOutput("simul_b_valid",  32'(m_tvalid), 1);
        checkOutput("simul_b0",       m_tdata, 'h60);
        checkOutput("simul_occ",      32'(occupancy), 2);
        applyStimulus(0, 0, 0, 1);
        checkOutput("simul_b1",      m_tdata, 'h61);
        checkOutput("simul_b1_last", 32'(m_tlast), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("simul_idle",    32'(m_tvalid), 0);
        checkOutput("simul_pkt0",    32'(pkt_count), 0);

`ifdef AXIS_PKT_TX_ABORT_EN
        // Abort drops the partial packet and the write in the same cycle.
        applyStimulus(1, 'h90, 0, 0);
        applyStimulus(1, 'h91, 0, 0);
        checkOutput("abort_occ_before", 32'(occupancy), 2);
        wr_abort = 1'b1;
        applyStimulus(1, 'h92, 1, 0);
        wr_abort = 1'b0;
        checkOutput("abort_occ_after", 32'(occupancy), 0);
        checkOutput("abort_tvalid",    32'(m_tvalid), 0);
        checkOutput("abort_pkt",       32'(pkt_count), 0);
        checkOutput("abort_ovf_kept",  32'(overflow), 1);
`endif

        // Reset asserted during the second beat of a 4-word packet.
        for (int i = 0; i < 4; i++) applyStimulus(1, 'h70 + i, (i == 3) ? 1'b1 : 1'b0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("rstmid_beat1", m_tdata, 'h71);
        #2 aresetn = 1'b0;
        #1;
        checkOutput("rstmid_tvalid", 32'(m_tvalid),  0);
        checkOutput("rstmid_pkt",    32'(pkt_count), 0);
        checkOutput("rstmid_occ",    32'(occupancy), 0);
        checkOutput("rstmid_ovf",    32'(overflow),  0);
        checkOutput("rstmid_full",   32'(wr_full),   0);
        #1 aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rstmid_no_stale", 32'(m_tvalid), 0);
        end
        applyStimulus(1, 'h80, 1, 1);
        checkOutput("rstmid_new_data", m_tdata, 'h80);
        checkOutput("rstmid_new_last", 32'(m_tlast), 1);
        checkOutput("rstmid_new_pkt",  32'(pkt_count), 1);
        tick();
        checkOutput("rstmid_new_done", 32'(m_tvalid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
